scan_sequencer_2bit: RTL

- Synchronous scan controller upstream of the 2-to-4 enable decoder; drives its G, S0, S1 inputs.
- Steps through the four output slots in time-multiplexed fashion, e.g. 4-digit 7-segment anode scanning.
- Holds each slot for a programmable dwell time, then inserts a blanking gap with G=0 to prevent ghosting.
- Skips masked slots.

---
 rtl/scan_sequencer_2bit.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/scan_sequencer_2bit.sv
// Time-multiplexed scan controller driving G/S1/S0 of a 2-to-4 enable decoder.
// Optional macro SCAN_HOLD_EN adds a HOLD input that freezes dwell/gap timing.
module scan_sequencer_2bit #(
    parameter int unsigned DIV       = 32'd50000,
    parameter int unsigned BLANK_CYC = 32'd4,
    parameter int unsigned CNT_W     = 32'd16
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       EN,
    input  logic [3:0] MASK,
`ifdef SCAN_HOLD_EN
    input  logic       HOLD,
`endif
    output logic       G,
    output logic       S0,
    output logic       S1,
    output logic       SLOT_START
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        SHOW = 2'b01,
        GAP  = 2'b10
    } state_t;

    localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(DIV - 32'd1);
    localparam logic [CNT_W-1:0] BLANK_LAST = (BLANK_CYC == 32'd0) ? '0 : CNT_W'(BLANK_CYC - 32'd1);

    // Returns {found, slot}: first unmasked slot after cur, wrapping, cur itself tried last.
    function automatic logic [2:0] pick_next(input logic [1:0] cur, input logic [3:0] mask);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int k = 4; k >= 1; k--) begin
            idx = cur + 2'(k);
            if (!mask[idx]) begin
                res = {1'b1, idx};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    state_t           state_q, state_d;
    logic [1:0]       slot_q, slot_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             g_q, g_d;
    logic             start_q, start_d;
    logic             hold_s;
    logic [2:0]       first_s;
    logic [2:0]       nxt_s;

`ifdef SCAN_HOLD_EN
    assign hold_s = HOLD;
`else
    assign hold_s = 1'b0;
`endif

    assign first_s = pick_next(2'b11, MASK);
    assign nxt_s   = pick_next(slot_q, MASK);

    // Next-state, counter and registered-output decode.
    always_comb begin
        state_d = state_q;
        slot_d  = slot_q;
        cnt_d   = cnt_q;
        g_d     = g_q;
        start_d = 1'b0;
        if (!EN) begin
            state_d = IDLE;
            slot_d  = 2'b00;
            cnt_d   = '0;
            g_d     = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = first_s[2] ? SHOW : IDLE;
                    slot_d  = first_s[2] ? first_s[1:0] : 2'b00;
                    cnt_d   = '0;
                    g_d     = first_s[2];
                    start_d = first_s[2];
                end
                SHOW: begin
                    if (hold_s) begin
                        cnt_d = cnt_q;
                    end else if (cnt_q != DIV_LAST) begin
                        cnt_d = cnt_q + CNT_W'(1'b1);
                    end else if (BLANK_CYC != 32'd0) begin
                        state_d = GAP;
                        g_d     = 1'b0;
                        cnt_d   = '0;
                    end else begin
                        // No blanking: hand straight over to the next slot, G stays high.
                        state_d = nxt_s[2] ? SHOW : IDLE;
                        slot_d  = nxt_s[2] ? nxt_s[1:0] : 2'b00;
                        cnt_d   = '0;
                        g_d     = nxt_s[2];
                        start_d = nxt_s[2];
                    end
                end
                GAP: begin
                    if (hold_s) begin
                        cnt_d = cnt_q;
                    end else if (cnt_q != BLANK_LAST) begin
                        cnt_d = cnt_q + CNT_W'(1'b1);
                    end else begin
                        state_d = nxt_s[2] ? SHOW : IDLE;
                        slot_d  = nxt_s[2] ? nxt_s[1:0] : 2'b00;
                        cnt_d   = '0;
                        g_d     = nxt_s[2];
                        start_d = nxt_s[2];
                    end
                end
                default: begin
                    state_d = IDLE;
                    slot_d  = 2'b00;
                    cnt_d   = '0;
                    g_d     = 1'b0;
                end
            endcase
        end
    end

    // State, counter and output registers with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= IDLE;
            slot_q  <= 2'b00;
            cnt_q   <= '0;
            g_q     <= 1'b0;
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
            cnt_q   <= cnt_d;
            g_q     <= g_d;
            start_q <= start_d;
        end
    end

    assign G          = g_q;
    assign S0         = slot_q[0];
    assign S1         = slot_q[1];
    assign SLOT_START = start_q;

endmodule
